// File: rtl/alu_8bit.sv
// Registered 8-bit signed ALU: add/sub with carry, logic ops, multiply,
// divide with remainder and signed compare; one-cycle latency.
module alu_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [2:0]  alu_op,
    input  logic        cin,
    output logic [15:0] result,
    output logic        cout,
    output logic [7:0]  div_rem
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_DIV = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    alu_op_e            w_op;
    logic signed [15:0] w_a16;
    logic signed [15:0] w_b16;
    logic signed [15:0] w_quot;
    logic signed [15:0] w_rem16;
    logic [8:0]         w_sum9;
    logic [8:0]         w_sub_rhs9;
    logic [15:0]        w_result;
    logic               w_cout;
    logic [7:0]         w_rem;

    assign w_op       = alu_op_e'(alu_op);
    assign w_a16      = {{8{a[7]}}, a};
    assign w_b16      = {{8{b[7]}}, b};
    assign w_sum9     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign w_sub_rhs9 = {1'b0, b} + {8'd0, cin};

    // Divide at 16 bits so -128 / -1 = +128 stays exact.
    always_comb begin
        w_quot  = '0;
        w_rem16 = '0;
        if (b != 8'd0) begin
            w_quot  = w_a16 / w_b16;
            w_rem16 = w_a16 % w_b16;
        end
    end

    always_comb begin
        w_result = '0;
        w_cout   = 1'b0;
        w_rem    = '0;
        case (w_op)
            OP_ADD: begin
                w_result = w_a16 + w_b16 + {15'd0, cin};
                w_cout   = w_sum9[8];
            end
            OP_SUB: begin
                w_result = w_a16 - w_b16 - {15'd0, cin};
                w_cout   = ({1'b0, a} < w_sub_rhs9);
            end
            OP_AND: w_result = {{8{a[7] & b[7]}}, a & b};
            OP_OR:  w_result = {{8{a[7] | b[7]}}, a | b};
            OP_XOR: w_result = {{8{a[7] ^ b[7]}}, a ^ b};
            OP_MUL: w_result = w_a16 * w_b16;
            OP_DIV: begin
                if (b == 8'd0) begin
                    w_rem  = a;
                    w_cout = 1'b1;
                end else begin
                    w_result = w_quot;
                    w_rem    = w_rem16[7:0];
                end
            end
            OP_SLT: w_result = {15'd0, (w_a16 < w_b16)};
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            cout    <= 1'b0;
            div_rem <= '0;
        end else begin
            result  <= w_result;
            cout    <= w_cout;
            div_rem <= w_rem;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector bench for alu_8bit: table of hand-computed results plus
// latency, mid-cycle operand change and asynchronous reset sequences.
module tb_alu_8bit;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  alu_op;
    logic        cin;
    logic [15:0] result;
    logic        cout;
    logic [7:0]  div_rem;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string              name;
        logic [2:0]         op;
        logic signed [7:0]  va;
        logic signed [7:0]  vb;
        logic               vcin;
        logic signed [15:0] exp_result;
        logic               exp_cout;
        logic signed [7:0]  exp_rem;
    } vec_t;

    vec_t vecs[$];

    alu_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .alu_op  (alu_op),
        .cin     (cin),
        .result  (result),
        .cout    (cout),
        .div_rem (div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic void add_vec(string n, logic [2:0] op, logic signed [7:0] va,
                                    logic signed [7:0] vb, logic vcin,
                                    logic signed [15:0] er, logic ec, logic signed [7:0] erem);
        vec_t v;
        v.name = n; v.op = op; v.va = va; v.vb = vb; v.vcin = vcin;
        v.exp_result = er; v.exp_cout = ec; v.exp_rem = erem;
        vecs.push_back(v);
    endfunction

    task automatic check(string n, logic signed [15:0] act, logic signed [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", n, act, exp);
        end
    endtask

    task automatic check_all(string n, logic signed [15:0] er, logic ec, logic signed [7:0] erem);
        check({n, ".result"}, $signed(result), er);
        check({n, ".cout"}, {15'd0, cout}, {15'd0, ec});
        check({n, ".rem"}, {{8{div_rem[7]}}, div_rem}, {{8{erem[7]}}, erem});
    endtask

    task automatic drive(logic [2:0] op, logic signed [7:0] va, logic signed [7:0] vb, logic vcin);
        alu_op = op; a = va; b = vb; cin = vcin;
    endtask

    initial begin
        add_vec("add_m5_3",    3'b000,   -5,    3, 1'b0,    -2, 1'b0,  0);
        add_vec("add_m120_5",  3'b000, -120,    5, 1'b0,  -115, 1'b0,  0);
        add_vec("add_m45_0",   3'b000,  -45,    0, 1'b0,   -45, 1'b0,  0);
        add_vec("add_m1_1_c",  3'b000,   -1,    1, 1'b1,     1, 1'b1,  0);
        add_vec("sub_5_m3",    3'b001,    5,   -3, 1'b0,     8, 1'b1,  0);
        add_vec("sub_11_m20",  3'b001,   11,  -20, 1'b0,    31, 1'b1,  0);
        add_vec("sub_100_m1",  3'b001,  100,   -1, 1'b0,   101, 1'b1,  0);
        add_vec("sub_110_m8",  3'b001,  110,   -8, 1'b0,   118, 1'b1,  0);
        add_vec("sub_3_5_c",   3'b001,    3,    5, 1'b1,    -3, 1'b1,  0);
        add_vec("sub_7_7",     3'b001,    7,    7, 1'b0,     0, 1'b0,  0);
        add_vec("mul_m4_3",    3'b101,   -4,    3, 1'b0,   -12, 1'b0,  0);
        add_vec("mul_50_40",   3'b101,   50,   40, 1'b0,  2000, 1'b0,  0);
        add_vec("mul_5_3_cin", 3'b101,    5,    3, 1'b1,    15, 1'b0,  0);
        add_vec("mul_5_0",     3'b101,    5,    0, 1'b0,     0, 1'b0,  0);
        add_vec("mul_m128sq",  3'b101, -128, -128, 1'b0, 16384, 1'b0,  0);
        add_vec("div_m9_2",    3'b110,   -9,    2, 1'b0,    -4, 1'b0, -1);
        add_vec("div_m9_3",    3'b110,   -9,    3, 1'b0,    -3, 1'b0,  0);
        add_vec("div_15_m4",   3'b110,   15,   -4, 1'b0,    -3, 1'b0,  3);
        add_vec("div_m121_m1", 3'b110, -121,   -1, 1'b0,   121, 1'b0,  0);
        add_vec("div_m128_m1", 3'b110, -128,   -1, 1'b0,   128, 1'b0,  0);
        add_vec("div_m9_0",    3'b110,   -9,    0, 1'b0,     0, 1'b1, -9);
        add_vec("and_0f_3c",   3'b010, 8'sh0F, 8'sh3C, 1'b1, 12, 1'b0, 0);
        add_vec("or_0f_3c",    3'b011, 8'sh0F, 8'sh3C, 1'b0, 63, 1'b0, 0);
        add_vec("xor_0f_3c",   3'b100, 8'sh0F, 8'sh3C, 1'b0, 51, 1'b0, 0);
        add_vec("and_sext",    3'b010, -128,   -1, 1'b0,  -128, 1'b0,  0);
        add_vec("slt_m1_1",    3'b111,   -1,    1, 1'b0,     1, 1'b0,  0);
        add_vec("slt_1_m1",    3'b111,    1,   -1, 1'b0,     0, 1'b0,  0);
        add_vec("slt_5_5",     3'b111,    5,    5, 1'b0,     0, 1'b0,  0);

        rst = 1'b1;
        drive(3'b000, 8'sd10, 8'sd20, 1'b0);
        #2;
        check_all("reset", 0, 1'b0, 0);
        @(posedge clk); #1;
        check_all("reset_held_edge", 0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].vcin);
            @(posedge clk); #1;
            check_all(vecs[i].name, vecs[i].exp_result, vecs[i].exp_cout, vecs[i].exp_rem);
        end

        // Latency: new op visible only after the next rising edge.
        @(negedge clk);
        drive(3'b110, -8'sd9, 8'sd2, 1'b0);
        #1;
        check_all("latency_hold", 0, 1'b0, 0);
        @(posedge clk); #1;
        check_all("latency_cap", -4, 1'b0, -1);

        // Operand change between edges must not reach the outputs.
        a = 8'sd15;
        #2;
        check_all("midcycle_operand", -4, 1'b0, -1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", 0, 1'b0, 0);
        @(posedge clk); #1;
        check_all("reset_hold_op", 0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("post_reset_wait", 0, 1'b0, 0);
        @(posedge clk); #1;
        check_all("first_capture", 7, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- Single-cycle, registered 8-bit signed ALU: add, subtract, multiply, divide (with remainder), bitwise logic, signed compare.
- Operands are combinational inputs; results are captured on the rising clock edge.
- Used as the arithmetic datapath leaf in the processor/datapath designs; stimulus is applied on the falling edge and results are sampled one rising edge later.

Parameters:
- none (operand width fixed at 8, result width fixed at 16)

Ports:
- clk      input   1   system clock, rising-edge active
- rst      input   1   asynchronous reset, active-high
- a        input   8   signed operand A (two's complement)
- b        input   8   signed operand B (two's complement)
- alu_op   input   3   operation select
- cin      input   1   carry-in (add) / borrow-in (sub); ignored by all other ops
- result   output  16  signed registered result
- cout     output  1   registered carry/borrow/error flag
- div_rem  output  8   signed registered remainder; valid for divide only

Behaviour:
- Reset: rst=1 asynchronously forces result=0, cout=0, div_rem=0; held while rst=1. The first capture occurs at the first rising clk edge after rst deasserts.
- Latency: 1 cycle. Next-state is computed combinationally from a, b, alu_op, cin and registered on posedge clk. Outputs are stable between edges.
- All arithmetic is signed and exact. Operands are sign-extended to 16 bits before computation, so no 16-bit result can overflow.
- alu_op=000 ADD:
  - result = a + b + cin.
  - cout = bit 8 of the unsigned sum {1'b0,a} + {1'b0,b} + cin.
- alu_op=001 SUB:
  - result = a - b - cin.
  - cout = 1 when unsigned(a) < unsigned(b) + cin (borrow), else 0.
- alu_op=010 AND: result = sign-extended (a & b); cout=0.
- alu_op=011 OR: result = sign-extended (a | b); cout=0.
- alu_op=100 XOR: result = sign-extended (a ^ b); cout=0.
- alu_op=101 MUL:
  - result = full 16-bit signed product a*b. Range -16256..16384; 16384 = (-128)*(-128) fits.
  - cout=0.
- alu_op=110 DIV:
  - result = signed quotient, truncated toward zero, sign-extended to 16 bits.
  - div_rem = remainder, taking the sign of the dividend, with a = q*b + r.
  - -128 / -1 = +128, representable in 16 bits; cout=0.
  - Divide by zero (b=0): result=0, div_rem=a, cout=1 (error flag).
- alu_op=111 SLT: result = 1 if a < b (signed), else 0; cout=0.
- div_rem is written with 0 on every non-divide op.
- cin changes on non-add/sub ops have no effect.
- Operand changes mid-cycle have no effect until the next rising edge.
- Reset asserted between edges clears the outputs immediately. Reset wins over a simultaneous clock edge.

Test Plan:
1. ADD:
   - a=-5, b=3, cin=0 -> result=-2, cout=0.
   - a=-120, b=5 -> result=-115, cout=0.
   - a=-45, b=0 -> result=-45, cout=0.
   - a=-1, b=1, cin=1 -> result=1, cout=1.
2. SUB:
   - a=5, b=-3 -> result=8, cout=1.
   - a=11, b=-20 -> result=31.
   - a=100, b=-1 -> result=101.
   - a=110, b=-8 -> result=118.
   - a=3, b=5, cin=1 -> result=-3, cout=1.
3. MUL:
   - a=-4, b=3 -> result=-12.
   - a=50, b=40 -> result=2000.
   - a=5, b=3 -> result=15.
   - a=5, b=0 -> result=0.
   - a=-128, b=-128 -> result=16384.
   - cout=0 for all.
4. DIV:
   - a=-9, b=2 -> result=-4, div_rem=-1.
   - a=-9, b=3 -> result=-3, div_rem=0.
   - a=15, b=-4 -> result=-3, div_rem=3.
   - a=-121, b=-1 -> result=121, div_rem=0.
   - a=-128, b=-1 -> result=128.
   - a=-9, b=0 -> result=0, div_rem=-9, cout=1.
5. Logic/compare:
   - a=8'h0F, b=8'h3C -> AND=12, OR=63, XOR=51.
   - SLT a=-1, b=1 -> result=1.
   - SLT a=1, b=-1 -> result=0.
6. Reset/latency:
   - Apply an op at negedge; result appears only after the next posedge.
   - Assert rst mid-cycle -> outputs go to 0 without a clock edge.
   - Deassert rst -> the first capture occurs at the next posedge.
